bist_pattern_gen: RTL

- Hardware pattern source sitting directly upstream of a combinational gate under test in fault-simulation and BIST benches.
- Replaces a bench-driven pattern register: drives the gate's input vector one pattern per accepted handshake, then reports completion.
- Two modes: exhaustive binary count, or a maximal-length Fibonacci LFSR.
- A downstream response checker consumes the gate output alongside `pat_out`/`pat_valid`.

---
 rtl/bist_pattern_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: handshake-paced pattern source for a combinational gate
// under test. Produces either an exhaustive binary count or a maximal-length
// Fibonacci LFSR sequence, one pattern per accepted pat_valid/pat_ready
// handshake, then signals completion. All outputs are registered.
module bist_pattern_gen #(
    parameter int unsigned       WIDTH   = 2,
    parameter logic [WIDTH-1:0]  POLY    = 2'b11,
    parameter logic [WIDTH-1:0]  SEED    = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned       NUM_PAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic [WIDTH-1:0] pat_out,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   pat_count
);

    localparam int unsigned NAT_EXH  = 32'd1 << WIDTH;
    localparam int unsigned TOT_EXH  = (NUM_PAT == 0) ? NAT_EXH : NUM_PAT;
    localparam int unsigned TOT_LFSR = (NUM_PAT == 0) ? (NAT_EXH - 1) : NUM_PAT;

    localparam logic [WIDTH:0]   TOTAL_EXH  = TOT_EXH[WIDTH:0];
    localparam logic [WIDTH:0]   TOTAL_LFSR = TOT_LFSR[WIDTH:0];
    localparam logic [WIDTH-1:0] PAT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   CNT_ONE    = {{WIDTH{1'b0}}, 1'b1};
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? PAT_ONE : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             mode_q;
    logic [WIDTH-1:0] pat_next;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH:0]   total;

    // Successor pattern, run length and incremented count for the latched mode.
    always_comb begin
        pat_next = pat_out + PAT_ONE;
        total    = TOTAL_EXH;
        if (mode_q) begin
            pat_next = {pat_out[WIDTH-2:0], ^(pat_out & POLY)};
            total    = TOTAL_LFSR;
        end
        cnt_inc = pat_count + CNT_ONE;
    end

    // Run control FSM with registered outputs; rst > abort > handshake/start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_out   <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_count <= '0;
            mode_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state     <= RUN;
                        mode_q    <= mode;
                        pat_out   <= mode ? SEED_EFF : '0;
                        pat_count <= '0;
                        pat_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        pat_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (pat_valid && pat_ready) begin
                        pat_count <= cnt_inc;
                        if (cnt_inc == total) begin
                            state     <= DONE;
                            pat_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pat_out <= pat_next;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pat_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
